cu_data_write_line_coalescer: RTL and testbench

- Writer-side counterpart of the cacheline data-read unpacker in the PageRank CSR PULL fixed-point compute unit.
- Accepts a stream of 8-byte fixed-point vertex results, each tagged with a vertex index.
- Packs consecutive results that fall in the same 128-byte cacheline into a single line buffer.
- Issues one full-line write command with per-byte enables toward the AFU command arbiter, tagged with the edge-data-write control ID.

---
 rtl/cu_data_write_line_coalescer.sv | 110 +++++++++++
 tb/tb_cu_data_write_line_coalescer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_data_write_line_coalescer.sv
// cu_data_write_line_coalescer: packs indexed 8-byte results into full-cacheline write commands
module cu_data_write_line_coalescer #(
    parameter int         CACHELINE_SIZE  = 128,
    parameter int         DATA_SIZE_WRITE = 8,
    parameter int         TIMEOUT_CYCLES  = 32,
    parameter logic [7:0] CU_ID           = 8'h0B
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable_in,
    input  logic [63:0]                 array_base_in,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    input  logic [31:0]                 data_in_index,
    input  logic [63:0]                 data_in_value,
    input  logic                        flush_in,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [63:0]                 cmd_address,
    output logic [CACHELINE_SIZE*8-1:0] cmd_data,
    output logic [CACHELINE_SIZE-1:0]   cmd_byte_enable,
    output logic [7:0]                  cmd_tag,
    output logic                        flush_done_out,
    output logic [31:0]                 lines_written_out
);
    localparam int ENTRIES = CACHELINE_SIZE / DATA_SIZE_WRITE;
    localparam int OFF_W   = $clog2(CACHELINE_SIZE);
    localparam int ENT_W   = $clog2(DATA_SIZE_WRITE);
    localparam int SLOT_W  = OFF_W - ENT_W;
    localparam int EW      = DATA_SIZE_WRITE * 8;
    localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;

    state_t                      state, state_next;
    logic [63:0]                 byte_addr, line_addr, held_line;
    logic [SLOT_W-1:0]           slot;
    logic [ENTRIES-1:0]          slot_mask, merged_mask;
    logic [CACHELINE_SIZE*8-1:0] line_data;
    logic [TW-1:0]               timer;
    logic                        same_line, accept, handshake;

    assign byte_addr   = array_base_in + (64'(data_in_index) << ENT_W);
    assign line_addr   = byte_addr & ~64'(CACHELINE_SIZE - 1);
    assign slot        = byte_addr[OFF_W-1:ENT_W];
    assign same_line   = line_addr == held_line;
    assign merged_mask = slot_mask | (ENTRIES'(1) << slot);
    assign accept      = data_in_valid && data_in_ready;
    assign handshake   = cmd_valid && cmd_ready;
    assign cmd_address = held_line;
    assign cmd_data    = line_data;
    assign cmd_tag     = CU_ID;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    // Leaving FILL: flush wins, then a line conflict, then a completed line, then the idle timeout
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: state_next = accept ? FILL : IDLE;
            FILL: state_next = (flush_in || (data_in_valid && !same_line) || (accept && &merged_mask) ||
                                (!accept && timer == TW'(TIMEOUT_CYCLES - 1))) ? EMIT : FILL;
            EMIT: state_next = cmd_ready ? IDLE : EMIT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid     = state == EMIT;
        data_in_ready = !reset && enable_in &&
                        (state == IDLE || (state == FILL && same_line && !flush_in));
    end

    always_comb begin
        cmd_byte_enable = '0;
        for (int i = 0; i < CACHELINE_SIZE; i++) cmd_byte_enable[i] = slot_mask[i/DATA_SIZE_WRITE];
    end

    always_ff @(posedge clock) begin
        if (reset || handshake) begin
            line_data <= '0;
            slot_mask <= '0;
        end else if (accept) begin
            slot_mask <= merged_mask;
            for (int k = 0; k < ENTRIES; k++)
                if (slot == SLOT_W'(k)) line_data[k*EW +: EW] <= data_in_value;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            held_line         <= '0;
            timer             <= '0;
            lines_written_out <= '0;
            flush_done_out    <= 1'b0;
        end else begin
            flush_done_out <= state == IDLE && flush_in && !accept;
            if (accept) begin
                held_line <= line_addr;
                timer     <= '0;
            end else if (state == FILL) begin
                timer <= timer + 1'b1;
            end
            if (handshake) lines_written_out <= lines_written_out + 1'b1;
        end
    end
endmodule

// File: tb/tb_cu_data_write_line_coalescer.sv
// tb_cu_data_write_line_coalescer: directed and randomized checks against a line-buffer model
module tb_cu_data_write_line_coalescer;
    localparam int TIMEOUT = 32;
    localparam logic [7:0] TAG = 8'h0B;

    logic          clock = 1'b0, reset = 1'b1, enable_in = 1'b0;
    logic [63:0]   array_base_in = '0;
    logic          data_in_valid = 1'b0, data_in_ready;
    logic [31:0]   data_in_index = '0;
    logic [63:0]   data_in_value = '0;
    logic          flush_in = 1'b0, cmd_valid, cmd_ready = 1'b0;
    logic [63:0]   cmd_address;
    logic [1023:0] cmd_data;
    logic [127:0]  cmd_byte_enable;
    logic [7:0]    cmd_tag;
    logic          flush_done_out;
    logic [31:0]   lines_written_out;

    cu_data_write_line_coalescer dut (
        .clock(clock), .reset(reset), .enable_in(enable_in), .array_base_in(array_base_in),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready), .data_in_index(data_in_index),
        .data_in_value(data_in_value), .flush_in(flush_in), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_address(cmd_address), .cmd_data(cmd_data), .cmd_byte_enable(cmd_byte_enable),
        .cmd_tag(cmd_tag), .flush_done_out(flush_done_out), .lines_written_out(lines_written_out)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;

    // Model: a held line (if any), its 16 entries with written flags, and whether it is being emitted
    bit          have, emitting, exp_fd, last_acc;
    logic [63:0] mline;
    logic [63:0] mdata [16];
    bit          mmask [16];
    int          quiet;
    logic [31:0] mlines;

    task automatic model_clear();
        have = 0; emitting = 0; exp_fd = 0; mline = '0; quiet = 0; mlines = '0;
        for (int k = 0; k < 16; k++) begin mdata[k] = '0; mmask[k] = 0; end
    endtask

    task automatic chk(string n, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%h exp=%h", n, $time, got, exp);
        end
    endtask

    task automatic chk_data();
        logic [1023:0] e;
        for (int k = 0; k < 16; k++) e[k*64 +: 64] = mdata[k];
        checks++;
        if (cmd_data !== e) begin
            errors++;
            for (int k = 0; k < 16; k++)
                if (cmd_data[k*64 +: 64] !== e[k*64 +: 64]) begin
                    $display("FAIL cmd_data entry %0d at %0t: got=%h exp=%h", k, $time, cmd_data[k*64 +: 64], e[k*64 +: 64]);
                    break;
                end
        end
    endtask

    // Compare DUT against the model mid-cycle, then advance the model across the next rising edge
    task automatic cycle();
        logic [63:0]  ba, la;
        logic [127:0] be;
        int           sl, filled;
        bit           er, acc, nfd;
        #1;
        ba = array_base_in + ({32'b0, data_in_index} << 3);
        la = {ba[63:7], 7'b0};
        sl = int'(ba[6:3]);
        er = !emitting && enable_in && (!have || (la == mline && !flush_in));
        chk("data_in_ready", 128'(data_in_ready), 128'(er));
        chk("cmd_valid", 128'(cmd_valid), 128'(emitting));
        chk("cmd_tag", 128'(cmd_tag), 128'(TAG));
        chk("flush_done_out", 128'(flush_done_out), 128'(exp_fd));
        chk("lines_written_out", 128'(lines_written_out), 128'(mlines));
        if (emitting) begin
            for (int i = 0; i < 128; i++) be[i] = mmask[i/8];
            chk("cmd_address", 128'(cmd_address), 128'(mline));
            chk("cmd_byte_enable", cmd_byte_enable, be);
            chk_data();
        end
        acc = data_in_valid && er;
        last_acc = acc;
        nfd = !have && flush_in && !acc;
        if (emitting) begin
            if (cmd_ready) begin
                for (int k = 0; k < 16; k++) begin mdata[k] = '0; mmask[k] = 0; end
                have = 0; emitting = 0; mlines++;
            end
        end else if (!have) begin
            if (acc) begin have = 1; mline = la; mdata[sl] = data_in_value; mmask[sl] = 1; quiet = 0; end
        end else if (flush_in || (data_in_valid && la != mline)) begin
            emitting = 1;
        end else if (acc) begin
            mdata[sl] = data_in_value; mmask[sl] = 1; quiet = 0;
            filled = 0;
            for (int k = 0; k < 16; k++) filled += int'(mmask[k]);
            if (filled == 16) emitting = 1;
        end else begin
            quiet++;
            if (quiet == TIMEOUT) emitting = 1;
        end
        exp_fd = nfd;
        @(negedge clock);
    endtask

    task automatic send(int idx, logic [63:0] v);
        data_in_valid = 1; data_in_index = idx; data_in_value = v;
        cycle();
        data_in_valid = 0;
    endtask

    task automatic run_random(int n, int pv, int groups);
        bit pend = 0;
        int grp = 0;
        for (int c = 0; c < n; c++) begin
            if ($urandom_range(19) == 0) grp = $urandom_range(groups - 1);
            if (!pend && $urandom_range(99) < pv) begin
                pend = 1;
                data_in_index = grp * 16 + $urandom_range(15);
                data_in_value = {$urandom, $urandom};
            end
            data_in_valid = pend;
            enable_in = $urandom_range(9) != 0;
            cmd_ready = $urandom_range(2) != 0;
            flush_in = $urandom_range(39) == 0;
            cycle();
            if (last_acc) pend = 0;
        end
        data_in_valid = 0; flush_in = 0; enable_in = 1; cmd_ready = 1;
        repeat (40) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_clear();
        repeat (2) @(negedge clock);
        #1;
        chk("reset_cmd_valid", 128'(cmd_valid), 0);
        chk("reset_lines", 128'(lines_written_out), 0);
        chk("reset_byte_enable", cmd_byte_enable, 0);
        chk("reset_data_any", 128'(|cmd_data), 0);
        chk("reset_flush_done", 128'(flush_done_out), 0);
        reset = 0; enable_in = 1; cmd_ready = 1; array_base_in = 64'h1000;
        cycle();

        // Full line of 16 consecutive entries
        for (int i = 0; i < 16; i++) send(i, 64'h100 + i);
        #1;
        chk("t1_cmd_valid", 128'(cmd_valid), 1);
        chk("t1_address", 128'(cmd_address), 128'h1000);
        chk("t1_byte_enable", cmd_byte_enable, {128{1'b1}});
        chk("t1_entry0", 128'(cmd_data[0 +: 64]), 128'h100);
        chk("t1_entry15", 128'(cmd_data[15*64 +: 64]), 128'h10F);
        cycle();
        chk("t1_lines", 128'(lines_written_out), 1);

        // Line conflict forces the partial line out, then the new line times out
        send(3, 64'h33);
        data_in_valid = 1; data_in_index = 20; data_in_value = 64'h20;
        #1 chk("t2_stall_ready", 128'(data_in_ready), 0);
        cycle();
        chk("t2_c1_valid", 128'(cmd_valid), 1);
        chk("t2_c1_address", 128'(cmd_address), 128'h1000);
        chk("t2_c1_byte_enable", cmd_byte_enable, 128'hFF << 24);
        cycle();
        #1 chk("t2_ready_idle", 128'(data_in_ready), 1);
        cycle();
        data_in_valid = 0;
        repeat (31) cycle();
        chk("t2_before_timeout", 128'(cmd_valid), 0);
        cycle();
        chk("t2_c2_valid", 128'(cmd_valid), 1);
        chk("t2_c2_address", 128'(cmd_address), 128'h1080);
        chk("t2_c2_byte_enable", cmd_byte_enable, 128'hFF << 32);
        chk("t2_c2_entry4", 128'(cmd_data[4*64 +: 64]), 128'h20);
        cycle();
        chk("t2_lines", 128'(lines_written_out), 3);

        // Mid-line base address
        array_base_in = 64'h1040;
        send(8, 64'h88);
        flush_in = 1;
        cycle();
        chk("t3_address", 128'(cmd_address), 128'h1080);
        chk("t3_byte_enable", cmd_byte_enable, 128'hFF);
        chk("t3_entry0", 128'(cmd_data[63:0]), 128'h88);
        cycle();
        cycle();
        flush_in = 0;
        #1 chk("t3_flush_done", 128'(flush_done_out), 1);
        cycle();
        chk("t3_flush_done_low", 128'(flush_done_out), 0);

        // Repeat write to one slot, then flush
        array_base_in = 64'h1000;
        send(5, 64'hA);
        send(5, 64'hB);
        flush_in = 1;
        cycle();
        chk("t4_entry5", 128'(cmd_data[5*64 +: 64]), 128'hB);
        chk("t4_byte_enable", cmd_byte_enable, 128'hFF << 40);
        cycle();
        #1 chk("t4_no_early_done", 128'(flush_done_out), 0);
        cycle();
        flush_in = 0;
        #1 chk("t4_flush_done", 128'(flush_done_out), 1);
        cycle();

        // Back-pressured command stays stable, then reset drops it
        cmd_ready = 0;
        send(1, 64'h55);
        flush_in = 1;
        cycle();
        flush_in = 0;
        data_in_valid = 1; data_in_index = 2; data_in_value = 64'h66;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t5_ready", 128'(data_in_ready), 0);
            chk("t5_valid", 128'(cmd_valid), 1);
            chk("t5_address", 128'(cmd_address), 128'h1000);
            chk("t5_byte_enable", cmd_byte_enable, 128'hFF << 8);
            cycle();
        end
        reset = 1; data_in_valid = 0;
        @(negedge clock);
        model_clear();
        reset = 0;
        #1;
        chk("t5_reset_valid", 128'(cmd_valid), 0);
        chk("t5_reset_lines", 128'(lines_written_out), 0);
        chk("t5_reset_byte_enable", cmd_byte_enable, 0);
        cmd_ready = 1;
        cycle();

        // Flush with an empty buffer
        flush_in = 1;
        cycle();
        flush_in = 0;
        #1;
        chk("t6_flush_done", 128'(flush_done_out), 1);
        chk("t6_no_cmd", 128'(cmd_valid), 0);
        cycle();
        chk("t6_flush_done_low", 128'(flush_done_out), 0);

        array_base_in = 64'h2000_0008;
        run_random(1500, 70, 4);
        run_random(1500, 3, 3);
        array_base_in = 64'hFFFF_FFFF_FFFF_FFC0;
        run_random(800, 60, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
